lane_packer: RTL and testbench
==============================

Name: lane_packer

Overview:
- Producer side of the packed 4-lane operand bus that feeds the registered four-lane adder.
- Accepts one W-bit lane per valid/ready beat and assembles lanes in order x, y, z, w into one 4*W bus, with x in the low bits.
- Emits each complete group, or a partial group closed by in_last, with a carry-in bit through a valid/ready output stage.
- Double-buffered (fill buffer plus output register), so back-to-back groups stream at one lane per cycle.

Parameters:
- W, 8, lane width in bits. out_ins is 4*W bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  lane value.
- in_cin  input  1  carry-in for the group; sampled only on the group's first beat (lane 0).
- in_last  input  1  closes the group on this beat; remaining lanes are zero-filled.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- out_ins  output  4*W  packed lanes: [W-1:0]=x, [2W-1:W]=y, [3W-1:2W]=z, [4W-1:3W]=w.
- out_cin  output  1  carry-in of the emitted group.
- out_lanes  output  3  number of real lanes in the group (1..4).
- out_valid  output  1  group valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.

Behaviour:
- Reset (async, while rst=1), all cleared:
  - out_ins=0, out_cin=0, out_lanes=0, out_valid=0.
  - Fill buffer=0, lane index idx=0, fill_full=0.
  - in_ready=1 one cycle after release.
- Any partial group in the fill buffer at reset is discarded. A group in the output register is dropped.
- Output slot is free when out_valid=0 or out_ready=1.
- Accept: a beat is accepted when in_valid & in_ready.
  - The beat is written to lane idx.
  - On idx==0, in_cin is captured and lanes 1..3 of the fill buffer are cleared.
- Close: the beat closes the group when idx==3 or in_last=1. Otherwise idx increments.
- On a closing beat with the slot free:
  - The output register loads the group on the same edge: out_ins, out_cin, out_lanes=idx+1, with unused upper lanes zero.
  - out_valid=1 after that edge. Latency is closing beat to out_valid = 1 cycle.
  - idx returns to 0.
- On a closing beat with the slot not free:
  - The group is held in the fill buffer and fill_full=1.
  - In any later cycle with fill_full=1 and the slot free, the group transfers to the output register, fill_full clears and idx=0.
- in_ready = ~fill_full (registered state only; no combinational path from out_ready).
- out_valid falls after an out_ready handshake unless a new group loads on the same edge; back-to-back loads keep out_valid=1.
- Output stability: while out_valid=1 and out_ready=0, out_ins, out_cin and out_lanes hold stable.
- Throughput: with out_ready tied to 1, one lane is accepted every cycle with no bubble between groups.
- in_last with idx==3 behaves as a normal full close (out_lanes=4).
- in_last on lane 0 gives out_lanes=1, lanes y/z/w=0.
- in_valid=0 mid-group: idx holds and the partial group waits indefinitely.
- Values are passed through unmodified; no arithmetic on lanes.

Optional Feature:
- Macro: LANE_PACKER_SUM_EN.
- When defined, two extra output ports are added and loaded on the same edge as out_ins (reset 0):
  - out_sum [W+1:0]: x+y+z+w+cin of the group, zero-extended, with no overflow at max operands.
  - out_sum_zero [1]: asserted when out_sum==0.
- These let downstream logic cross-check adder results.
- When undefined, the ports and the sum logic are absent, and all other behaviour is identical.

Test Plan:
- W=8, out_ready=1, beats 0x11,0x22,0x33,0x44 with cin=1 on first beat -> one cycle after 4th beat: out_ins=0x44332211, out_cin=1, out_lanes=4, out_valid=1 for exactly 1 cycle.
- Beats 0xAA, 0xBB(in_last=1), cin=0 -> out_ins=0x0000BBAA, out_lanes=2. Next group 0x01..0x04 is packed from lane 0 -> 0x04030201.
- out_ready=0, stream 8 beats -> first group held stable in out_ins; second fills buffer; in_ready=0 after 8th beat. Raise out_ready for one cycle -> second group appears next cycle, in_ready=1.
- Continuous valid with out_ready=1 over 3 groups (12 beats) -> in_ready never drops; out_valid high on 3 separate edges, 4 cycles apart.
- rst pulsed asynchronously after 2 of 4 beats -> outputs 0 immediately. Following 4 beats 0x05,0x06,0x07,0x08 -> out_ins=0x08070605 (no stale lanes).
- With LANE_PACKER_SUM_EN: lanes 0xFF×4, cin=1 -> out_sum=0x3FD, out_sum_zero=0. Lanes 0×4, cin=0 -> out_sum=0, out_sum_zero=1.

Source files
------------

// File: rtl/lane_packer.sv
// lane_packer: packs W-bit lanes x,y,z,w (x lowest) into a 4*W operand bus with carry-in,
// double-buffered (fill buffer + output register). Optional macro: LANE_PACKER_SUM_EN.
module lane_packer #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   in_data,
   input  logic           in_cin,
   input  logic           in_last,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [4*W-1:0] out_ins,
   output logic           out_cin,
   output logic [2:0]     out_lanes,
   output logic           out_valid,
   input  logic           out_ready
`ifdef LANE_PACKER_SUM_EN
   ,
   output logic [W+1:0]   out_sum,
   output logic           out_sum_zero
`endif
);

   logic [3:0][W-1:0] fill_buf;
   logic [3:0][W-1:0] merged;
   logic              fill_cin;
   logic              fill_full;
   logic [1:0]        idx;
   logic              grp_cin;
   logic              slot_free;
   logic              accept;
   logic              close;
   logic              load;

   assign slot_free = ~out_valid | out_ready;
   assign in_ready  = ~fill_full;
   assign accept    = in_valid & ~fill_full;
   assign close     = accept & ((idx == 2'd3) | in_last);
   assign load      = (fill_full | close) & slot_free;

   // merged is both the next fill buffer and the group to load; a lane-0 beat
   // clears the upper lanes so short groups never carry stale data.
   always_comb begin
      merged = fill_buf;
      for (int i = 0; i < 4; i++) begin
         if (accept && idx == 2'(i))
            merged[i] = in_data;
         else if (accept && idx == 2'd0)
            merged[i] = '0;
      end
   end

   assign grp_cin = (accept && idx == 2'd0) ? in_cin : fill_cin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_buf  <= '0;
         fill_cin  <= 1'b0;
         fill_full <= 1'b0;
         idx       <= 2'd0;
         out_ins   <= '0;
         out_cin   <= 1'b0;
         out_lanes <= 3'd0;
         out_valid <= 1'b0;
      end else begin
         fill_buf <= merged;
         if (accept && idx == 2'd0)
            fill_cin <= in_cin;
         if (load) begin
            // idx still points at the closing lane, whether direct or from the held group
            out_ins   <= merged;
            out_cin   <= grp_cin;
            out_lanes <= {1'b0, idx} + 3'd1;
            out_valid <= 1'b1;
            idx       <= 2'd0;
            fill_full <= 1'b0;
         end else begin
            if (out_ready)
               out_valid <= 1'b0;
            if (close)
               fill_full <= 1'b1;
            else if (accept)
               idx <= idx + 2'd1;
         end
      end
   end

`ifdef LANE_PACKER_SUM_EN
   logic [W+1:0] grp_sum;

   always_comb begin
      grp_sum = {{(W+1){1'b0}}, grp_cin};
      for (int i = 0; i < 4; i++)
         grp_sum = grp_sum + {2'b00, merged[i]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum      <= '0;
         out_sum_zero <= 1'b0;
      end else if (load) begin
         out_sum      <= grp_sum;
         out_sum_zero <= (grp_sum == '0);
      end
   end
`endif

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: directed plan steps plus random traffic against a queue-based group model.
module tb_lane_packer;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   in_data = '0;
   logic           in_cin = 1'b0;
   logic           in_last = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [4*W-1:0] out_ins;
   logic           out_cin;
   logic [2:0]     out_lanes;
   logic           out_valid;
   logic           out_ready = 1'b1;
`ifdef LANE_PACKER_SUM_EN
   logic [W+1:0]   out_sum;
   logic           out_sum_zero;
`endif

   lane_packer #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_cin(in_cin), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_ins(out_ins), .out_cin(out_cin), .out_lanes(out_lanes),
      .out_valid(out_valid), .out_ready(out_ready)
`ifdef LANE_PACKER_SUM_EN
      , .out_sum(out_sum), .out_sum_zero(out_sum_zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4*W-1:0] ins;
      logic           cin;
      logic [2:0]     lanes;
      logic [W+1:0]   sum;
   } grp_t;

   int         n_chk = 0;
   int         n_fail = 0;
   grp_t       exp_q[$];      // completed groups not yet taken downstream, oldest first
   logic [W-1:0] part[$];     // lanes of the group being assembled
   logic       part_cin = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_beat(input logic [W-1:0] d, input logic c, input logic l);
      grp_t g;
      if (part.size() == 0) part_cin = c;
      part.push_back(d);
      if (part.size() == 4 || l) begin
         g.ins = '0;
         g.sum = {{(W+1){1'b0}}, part_cin};
         foreach (part[i]) begin
            g.ins[i*W +: W] = part[i];
            g.sum = g.sum + {2'b00, part[i]};
         end
         g.cin   = part_cin;
         g.lanes = 3'(part.size());
         exp_q.push_back(g);
         part.delete();
      end
   endfunction

   // One clock: note handshakes from pre-edge values, advance the model, then
   // check that visible state matches the outstanding-group queue.
   task automatic tick();
      logic acc, ohs;
      logic [W-1:0] d;
      logic c, l;
      grp_t f;
      acc = in_valid & in_ready;
      ohs = out_valid & out_ready;
      d = in_data; c = in_cin; l = in_last;
      @(posedge clk);
      #1;
      if (ohs) begin
         chk("hs_has_group", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) model_beat(d, c, l);
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
         f = exp_q[0];
         chk("out_ins", out_ins, f.ins);
         chk("out_cin", out_cin, f.cin);
         chk("out_lanes", out_lanes, f.lanes);
`ifdef LANE_PACKER_SUM_EN
         chk("out_sum", out_sum, f.sum);
         chk("out_sum_zero", out_sum_zero, f.sum == '0);
`endif
      end
   endtask

   task automatic drive(input logic [W-1:0] d, input logic c, input logic l);
      in_valid = 1'b1; in_data = d; in_cin = c; in_last = l;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_last = 1'b0; in_cin = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4*W-1:0] held;
      logic           pv, pr;
      logic           done;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ins", out_ins, 0);
      chk("rst_out_cin", out_cin, 0);
      chk("rst_out_lanes", out_lanes, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // full group, out_valid for exactly one cycle
      out_ready = 1'b1;
      drive(8'h11, 1'b1, 1'b0); tick();
      drive(8'h22, 1'b0, 1'b0); tick();
      drive(8'h33, 1'b0, 1'b0); tick();
      drive(8'h44, 1'b0, 1'b0); tick();
      idle();
      chk("g1_ins", out_ins, 32'h44332211);
      chk("g1_cin", out_cin, 1);
      chk("g1_lanes", out_lanes, 4);
      chk("g1_valid", out_valid, 1);
      tick();
      chk("g1_valid_drop", out_valid, 0);

      // short group closed by in_last, then a fresh group from lane 0
      drive(8'hAA, 1'b0, 1'b0); tick();
      drive(8'hBB, 1'b0, 1'b1); tick();
      chk("g2_ins", out_ins, 32'h0000BBAA);
      chk("g2_lanes", out_lanes, 2);
      for (int i = 1; i <= 4; i++) begin
         drive(W'(i), 1'b0, 1'b0); tick();
      end
      idle();
      chk("g3_ins", out_ins, 32'h04030201);
      chk("g3_lanes", out_lanes, 4);
      tick();

      // last on lane 0 gives a single-lane group
      drive(8'h5A, 1'b1, 1'b1); tick(); idle();
      chk("g_one_ins", out_ins, 32'h0000005A);
      chk("g_one_lanes", out_lanes, 1);
      tick();

      // backpressure: two groups outstanding, then one handshake
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(W'(8'h10 + i), 1'b0, 1'b0); tick();
         if (i == 3) held = out_ins;
      end
      idle();
      chk("bp_held", out_ins, 32'h13121110);
      chk("bp_in_ready", in_ready, 0);
      tick(); tick();
      chk("bp_stable", out_ins, held);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_second", out_ins, 32'h17161514);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready_back", in_ready, 1);
      out_ready = 1'b1;
      tick();

      // continuous stream of three groups
      for (int k = 0; k < 12; k++) begin
         drive(W'($urandom), 1'(k % 4 == 0), 1'b0); tick();
         chk("tp_in_ready", in_ready, 1);
         chk("tp_valid_phase", out_valid, k % 4 == 3);
      end
      idle();
      tick();

      // async reset mid-group with a group in the output register
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(W'(8'hA0 + i), 1'b0, 1'b0); tick();
      end
      idle();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ins", out_ins, 0);
      chk("arst_lanes", out_lanes, 0);
      exp_q.delete();
      part.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      chk("arst_in_ready", in_ready, 1);
      for (int i = 5; i <= 8; i++) begin
         drive(W'(i), 1'b0, 1'b0); tick();
      end
      idle();
      chk("arst_fresh", out_ins, 32'h08070605);
      tick();

`ifdef LANE_PACKER_SUM_EN
      for (int i = 0; i < 4; i++) begin
         drive(8'hFF, 1'b1, 1'b0); tick();
      end
      idle();
      chk("sum_max", out_sum, 10'h3FD);
      chk("sum_max_zero", out_sum_zero, 0);
      for (int i = 0; i < 4; i++) begin
         drive(8'h00, 1'b0, 1'b0); tick();
      end
      idle();
      chk("sum_nil", out_sum, 0);
      chk("sum_nil_zero", out_sum_zero, 1);
      tick();
`endif

      // random traffic
      for (int k = 0; k < 600; k++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         in_cin    = 1'($urandom);
         in_last   = 1'($urandom_range(0, 4) == 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         pv = out_valid; pr = out_ready; held = out_ins;
         tick();
         if (pv && !pr) begin
            chk("rnd_hold_valid", out_valid, 1);
            chk("rnd_hold_ins", out_ins, held);
         end
      end

      // close any partial group and drain
      drive(8'h7E, 1'b0, 1'b1);
      out_ready = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         done = in_ready;
         tick();
      end
      chk("drain_accept", done, 1);
      idle();
      repeat (4) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
